// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants for the 640x480@60 Hz (800x521) mode.
// Renderers take their back-porch offsets (HBP/VBP) from here.
package vga_timing_pkg;

    localparam int unsigned CNT_W   = 10;
    localparam int unsigned DIV_W   = 4;

    localparam int unsigned HPIXELS = 800;
    localparam int unsigned VLINES  = 521;
    localparam int unsigned HSW     = 128;
    localparam int unsigned VSW     = 2;
    localparam int unsigned HBP     = 144;
    localparam int unsigned HFP     = 784;
    localparam int unsigned VBP     = 31;
    localparam int unsigned VFP     = 511;

    typedef logic [CNT_W-1:0] coord_t;

    localparam coord_t COORD_ZERO = 10'd0;
    localparam coord_t COORD_ONE  = 10'd1;

    // Half-open window test [lo, hi) on 10-bit unsigned coordinates.
    function automatic logic in_window(coord_t pos, coord_t lo, coord_t hi);
        return (pos >= lo) && (pos < hi);
    endfunction

endpackage

// File: rtl/pix_clk_div.sv
// pix_clk_div: divides the system clock down to the pixel rate.
// adv_o tells the owner to step its counters on this edge; pix_tick_o is the
// registered strobe that is high for the clock in which the new position shows.
module pix_clk_div #(
    parameter int unsigned DIV = 4
) (
    input  logic clk_i,
    input  logic clr_n_i,
    input  logic en_i,
    output logic adv_o,
    output logic pix_tick_o
);
    import vga_timing_pkg::*;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ZERO = 4'd0;
    localparam logic [DIV_W-1:0] DIV_ONE  = 4'd1;

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             tick_q;
    logic             tick_d;

    // Divider next state: count 0..DIV-1 while enabled, hold otherwise.
    always_comb begin
        div_d  = div_q;
        tick_d = 1'b0;
        adv_o  = 1'b0;
        if (en_i) begin
            if (div_q == DIV_LAST) begin
                div_d  = DIV_ZERO;
                tick_d = 1'b1;
                adv_o  = 1'b1;
            end else begin
                div_d  = div_q + DIV_ONE;
            end
        end else begin
            div_d  = div_q;
        end
    end

    // Divider and tick registers; asynchronous clear to the idle state.
    always_ff @(posedge clk_i or negedge clr_n_i) begin
        if (!clr_n_i) begin
            div_q  <= DIV_ZERO;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            tick_q <= tick_d;
        end
    end

    assign pix_tick_o = tick_q;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster position, sync, visible-window and frame pulses.
// All decoded outputs are computed from the next-state counters and
// registered alongside them, so they always describe the current hc/vc.
module vga_timing_gen #(
    parameter int unsigned DIV     = 4,
    parameter int unsigned HPIXELS = vga_timing_pkg::HPIXELS,
    parameter int unsigned VLINES  = vga_timing_pkg::VLINES,
    parameter int unsigned HSW     = vga_timing_pkg::HSW,
    parameter int unsigned VSW     = vga_timing_pkg::VSW,
    parameter int unsigned HBP     = vga_timing_pkg::HBP,
    parameter int unsigned HFP     = vga_timing_pkg::HFP,
    parameter int unsigned VBP     = vga_timing_pkg::VBP,
    parameter int unsigned VFP     = vga_timing_pkg::VFP
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       en,
    output logic [9:0] hc,
    output logic [9:0] vc,
    output logic       hsync,
    output logic       vsync,
    output logic       vidon,
    output logic       pix_tick,
    output logic       frame_start,
    output logic       vblank_start,
    output logic [7:0] frame_cnt
);
    import vga_timing_pkg::*;

    localparam coord_t H_LAST = coord_t'(HPIXELS - 1);
    localparam coord_t V_LAST = coord_t'(VLINES - 1);
    localparam coord_t H_SW   = coord_t'(HSW);
    localparam coord_t V_SW   = coord_t'(VSW);
    localparam coord_t H_BP   = coord_t'(HBP);
    localparam coord_t H_FP   = coord_t'(HFP);
    localparam coord_t V_BP   = coord_t'(VBP);
    localparam coord_t V_FP   = coord_t'(VFP);

    logic       adv_s;
    coord_t     hc_q, hc_d;
    coord_t     vc_q, vc_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       vidon_q, vidon_d;
    logic       frame_start_q, frame_start_d;
    logic       vblank_start_q, vblank_start_d;

    pix_clk_div #(
        .DIV        (DIV)
    ) u_pix_clk_div (
        .clk_i      (clk),
        .clr_n_i    (clr_n),
        .en_i       (en),
        .adv_o      (adv_s),
        .pix_tick_o (pix_tick)
    );

    // Position next state: step hc on each pixel, wrap into vc, then frames.
    always_comb begin
        hc_d        = hc_q;
        vc_d        = vc_q;
        frame_cnt_d = frame_cnt_q;
        if (adv_s) begin
            if (hc_q == H_LAST) begin
                hc_d = COORD_ZERO;
                if (vc_q == V_LAST) begin
                    vc_d        = COORD_ZERO;
                    frame_cnt_d = frame_cnt_q + 8'd1;
                end else begin
                    vc_d        = vc_q + COORD_ONE;
                end
            end else begin
                hc_d = hc_q + COORD_ONE;
            end
        end else begin
            hc_d = hc_q;
        end
    end

    // Decode sync, window and boundary pulses from the position being loaded.
    always_comb begin
        hsync_d        = (hc_d >= H_SW);
        vsync_d        = (vc_d >= V_SW);
        vidon_d        = in_window(hc_d, H_BP, H_FP) && in_window(vc_d, V_BP, V_FP);
        frame_start_d  = adv_s && (hc_d == COORD_ZERO) && (vc_d == COORD_ZERO);
        vblank_start_d = adv_s && (hc_d == COORD_ZERO) && (vc_d == V_FP);
    end

    // Position and decoded outputs update together; clear is asynchronous.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            hc_q           <= COORD_ZERO;
            vc_q           <= COORD_ZERO;
            frame_cnt_q    <= 8'd0;
            hsync_q        <= 1'b0;
            vsync_q        <= 1'b0;
            vidon_q        <= 1'b0;
            frame_start_q  <= 1'b0;
            vblank_start_q <= 1'b0;
        end else begin
            hc_q           <= hc_d;
            vc_q           <= vc_d;
            frame_cnt_q    <= frame_cnt_d;
            hsync_q        <= hsync_d;
            vsync_q        <= vsync_d;
            vidon_q        <= vidon_d;
            frame_start_q  <= frame_start_d;
            vblank_start_q <= vblank_start_d;
        end
    end

    assign hc           = hc_q;
    assign vc           = vc_q;
    assign frame_cnt    = frame_cnt_q;
    assign hsync        = hsync_q;
    assign vsync        = vsync_q;
    assign vidon        = vidon_q;
    assign frame_start  = frame_start_q;
    assign vblank_start = vblank_start_q;

endmodule
